spi_reg_bridge: RTL and testbench

- Consumes the byte stream from the SPI slave and turns it into register accesses on a small 8-bit register bank.
- Frame format: first byte is the command; following bytes are data with address auto-increment.
- Register 0 drives the board LEDs. The block supplies the next byte the SPI slave shifts back to the Pi.
- All inputs are already resynchronised into the clk domain upstream; the block is fully synchronous to clk.

---
 rtl/spi_reg_bridge_if.sv | 11 +
 rtl/spi_reg_bridge.sv | 157 +++++++++++++++
 tb/tb_spi_reg_bridge.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_reg_bridge_if.sv
// Byte-level link between the SPI slave shifter and the register bridge.
// The master side supplies chip select and received bytes; the bridge returns the next byte to shift out.
interface spi_reg_bridge_if;
  logic       cs_n;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic [7:0] tx_byte;

  modport master (output cs_n, output rx_valid, output rx_byte, input tx_byte);
  modport slave  (input cs_n, input rx_valid, input rx_byte, output tx_byte);
endinterface

// File: rtl/spi_reg_bridge.sv
// Turns SPI frames (command byte, then auto-incrementing data bytes) into accesses on a small 8-bit register bank.
// Address 7'h7F accepts only the 8'h00 "clear oob_err" write; other data written there is dropped.
module spi_reg_bridge #(
  parameter int         NUM_REGS    = 4,
  parameter logic [7:0] STATUS_BYTE = 8'hA5,
  parameter logic [7:0] REG_RESET   = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spi_reg_bridge_if.slave       bus,
  output logic [NUM_REGS*8-1:0] reg_out,
  output logic                  wr_strobe,
  output logic [6:0]            wr_addr,
  output logic                  oob_err
);

  localparam logic [7:0] NUM_REGS_W   = 8'(NUM_REGS);
  localparam logic [6:0] OOB_CLR_ADDR = 7'h7F;

  typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, DATA = 2'd2} state_t;

  state_t     state_reg, state_next;
  logic [7:0] tx_reg, tx_next;
  logic [6:0] addr_reg, addr_next;
  logic       rw_reg, rw_next;
  logic       wr_strobe_reg, wr_strobe_next;
  logic [6:0] wr_addr_reg, wr_addr_next;
  logic       oob_reg, oob_next;
  logic       wr_en;

  logic [7:0] regs_reg [NUM_REGS];

  logic [6:0] cmd_addr;
  logic [6:0] addr_inc;
  logic       cmd_in_range, cur_in_range, inc_in_range;
  logic [7:0] cmd_rd_data, inc_rd_data;

  assign cmd_addr     = bus.rx_byte[6:0];
  assign addr_inc     = addr_reg + 7'd1;
  assign cmd_in_range = ({1'b0, cmd_addr} < NUM_REGS_W);
  assign cur_in_range = ({1'b0, addr_reg} < NUM_REGS_W);
  assign inc_in_range = ({1'b0, addr_inc} < NUM_REGS_W);

  // Unmatched addresses fall through to 8'h00, which is exactly the out-of-range read value.
  always_comb begin
    cmd_rd_data = 8'h00;
    inc_rd_data = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (cmd_addr == 7'(i)) cmd_rd_data = regs_reg[i];
      if (addr_inc == 7'(i)) inc_rd_data = regs_reg[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (!bus.cs_n) state_next = CMD;
      CMD: begin
        if (bus.cs_n)          state_next = IDLE;
        else if (bus.rx_valid) state_next = DATA;
      end
      DATA:    if (bus.cs_n) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tx_next        = tx_reg;
    addr_next      = addr_reg;
    rw_next        = rw_reg;
    wr_en          = 1'b0;
    wr_strobe_next = 1'b0;
    wr_addr_next   = wr_addr_reg;
    oob_next       = oob_reg;
    case (state_reg)
      IDLE: tx_next = STATUS_BYTE;
      CMD: begin
        if (bus.cs_n) begin
          tx_next = STATUS_BYTE;
        end else if (bus.rx_valid) begin
          rw_next   = bus.rx_byte[7];
          addr_next = cmd_addr;
          tx_next   = bus.rx_byte[7] ? 8'h00 : cmd_rd_data;
          if (!cmd_in_range) oob_next = 1'b1;
        end
      end
      DATA: begin
        if (bus.cs_n) begin
          tx_next = STATUS_BYTE;
        end else if (bus.rx_valid) begin
          addr_next = addr_inc;
          if (rw_reg) begin
            tx_next = 8'h00;
            if (addr_reg == OOB_CLR_ADDR && bus.rx_byte == 8'h00) begin
              oob_next = 1'b0;
            end else if (cur_in_range && addr_reg != OOB_CLR_ADDR) begin
              wr_en          = 1'b1;
              wr_strobe_next = 1'b1;
              wr_addr_next   = addr_reg;
            end else if (!cur_in_range) begin
              oob_next = 1'b1;
            end
          end else begin
            tx_next = inc_rd_data;
            if (!inc_in_range) oob_next = 1'b1;
          end
        end
      end
      default: tx_next = STATUS_BYTE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_reg        <= STATUS_BYTE;
      addr_reg      <= 7'd0;
      rw_reg        <= 1'b0;
      wr_strobe_reg <= 1'b0;
      wr_addr_reg   <= 7'd0;
      oob_reg       <= 1'b0;
    end else begin
      tx_reg        <= tx_next;
      addr_reg      <= addr_next;
      rw_reg        <= rw_next;
      wr_strobe_reg <= wr_strobe_next;
      wr_addr_reg   <= wr_addr_next;
      oob_reg       <= oob_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_reg[i] <= REG_RESET;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_REGS; i++)
        if (addr_reg == 7'(i)) regs_reg[i] <= bus.rx_byte;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg_view
      assign reg_out[gi*8 +: 8] = regs_reg[gi];
    end
  endgenerate

  assign bus.tx_byte = tx_reg;
  assign wr_strobe   = wr_strobe_reg;
  assign wr_addr     = wr_addr_reg;
  assign oob_err     = oob_reg;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Scoreboard bench: two bridges (4 and 128 registers) share the byte stream, each with its own chip select.
// Stimulus pushes expected tx bytes and writes; a monitor pops and compares as the DUTs respond.
module tb_spi_reg_bridge;
  logic clk = 1'b0;
  logic rst_n;
  logic cs0_n, cs1_n, rx_valid;
  logic [7:0] rx_byte;

  always #5 clk = ~clk;

  spi_reg_bridge_if if0 ();
  spi_reg_bridge_if if1 ();
  assign if0.cs_n = cs0_n;  assign if0.rx_valid = rx_valid;  assign if0.rx_byte = rx_byte;
  assign if1.cs_n = cs1_n;  assign if1.rx_valid = rx_valid;  assign if1.rx_byte = rx_byte;

  logic [31:0]   reg_out0;
  logic [1023:0] reg_out1;
  logic          wr_strobe0, wr_strobe1, oob0, oob1;
  logic [6:0]    wr_addr0, wr_addr1;

  spi_reg_bridge #(.NUM_REGS(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0), .reg_out(reg_out0),
    .wr_strobe(wr_strobe0), .wr_addr(wr_addr0), .oob_err(oob0));
  spi_reg_bridge #(.NUM_REGS(128)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1), .reg_out(reg_out1),
    .wr_strobe(wr_strobe1), .wr_addr(wr_addr1), .oob_err(oob1));

  typedef struct { int dut; logic [7:0] val; } tx_exp_t;
  typedef struct { int dut; logic [6:0] addr; logic [7:0] data; } wr_exp_t;
  tx_exp_t tx_q[$];
  wr_exp_t wr_q[$];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else begin
      $display("ok   %s value=%h", name, act);
    end
  endtask

  task automatic start_frame(input int d);
    @(posedge clk); #1;
    if (d == 0) cs0_n = 1'b0; else cs1_n = 1'b0;
  endtask

  task automatic send(input int d, input logic [7:0] b, input logic [7:0] exp_tx);
    tx_exp_t t;
    @(posedge clk); #1;
    t.dut = d; t.val = exp_tx;
    tx_q.push_back(t);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic expect_wr(input int d, input logic [6:0] a, input logic [7:0] v);
    wr_exp_t w;
    w.dut = d; w.addr = a; w.data = v;
    wr_q.push_back(w);
  endtask

  task automatic end_frame();
    @(posedge clk); #1;
    cs0_n = 1'b1; cs1_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: one tx comparison per accepted byte, one write comparison per wr_strobe pulse.
  initial begin
    logic    got;
    tx_exp_t t;
    wr_exp_t w;
    forever begin
      @(posedge clk);
      got = rx_valid && rst_n;
      @(negedge clk);
      if (got) begin
        if (tx_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL tx_unexpected actual=byte_accepted required=no_byte");
        end else begin
          t = tx_q.pop_front();
          check($sformatf("tx_byte dut%0d", t.dut), {24'd0, (t.dut == 0) ? if0.tx_byte : if1.tx_byte}, {24'd0, t.val});
        end
      end
      if (wr_strobe0 || wr_strobe1) begin
        if (wr_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL wr_unexpected actual=strobe dut0=%0b dut1=%0b required=none", wr_strobe0, wr_strobe1);
        end else begin
          w = wr_q.pop_front();
          check("wr_dut", wr_strobe1 ? 32'd1 : 32'd0, 32'(w.dut));
          if (w.dut == 0) begin
            check("wr_addr dut0", {25'd0, wr_addr0}, {25'd0, w.addr});
            check("wr_data dut0", {24'd0, reg_out0[w.addr[1:0]*8 +: 8]}, {24'd0, w.data});
          end else begin
            check("wr_addr dut1", {25'd0, wr_addr1}, {25'd0, w.addr});
            check("wr_data dut1", {24'd0, reg_out1[w.addr*8 +: 8]}, {24'd0, w.data});
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; cs0_n = 1'b0; cs1_n = 1'b0; rx_valid = 1'b0; rx_byte = 8'h81;
    repeat (6) begin
      @(posedge clk); #1;
      rx_valid = ~rx_valid;
    end
    rx_valid = 1'b0; cs0_n = 1'b1; cs1_n = 1'b1;
    @(negedge clk);
    check("rst reg_out0", reg_out0, 32'h0);
    check("rst reg_out1_lo", reg_out1[31:0], 32'h0);
    check("rst tx0", {24'd0, if0.tx_byte}, 32'hA5);
    check("rst wr_strobe0", {31'd0, wr_strobe0}, 32'd0);
    check("rst oob0", {31'd0, oob0}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle tx0", {24'd0, if0.tx_byte}, 32'hA5);

    // Burst write
    start_frame(0);
    send(0, 8'h80, 8'h00);
    expect_wr(0, 7'd0, 8'h11); send(0, 8'h11, 8'h00);
    expect_wr(0, 7'd1, 8'h22); send(0, 8'h22, 8'h00);
    expect_wr(0, 7'd2, 8'h33); send(0, 8'h33, 8'h00);
    end_frame();
    check("burst reg_out0", reg_out0, 32'h00332211);
    check("burst oob0", {31'd0, oob0}, 32'd0);
    check("burst end tx0", {24'd0, if0.tx_byte}, 32'hA5);

    // Read with auto-increment
    start_frame(0);
    send(0, 8'h01, 8'h22);
    send(0, 8'hFF, 8'h33);
    send(0, 8'hFF, 8'h00);
    end_frame();
    check("read oob0", {31'd0, oob0}, 32'd0);

    // Out-of-range write, then the 7F/00 clear
    start_frame(0);
    send(0, 8'h85, 8'h00);
    send(0, 8'h5A, 8'h00);
    end_frame();
    check("oob set", {31'd0, oob0}, 32'd1);
    check("oob reg_out0", reg_out0, 32'h00332211);
    start_frame(0);
    send(0, 8'hFF, 8'h00);
    send(0, 8'h00, 8'h00);
    end_frame();
    check("oob cleared", {31'd0, oob0}, 32'd0);

    // Read running past the last register
    start_frame(0);
    send(0, 8'h03, 8'h00);
    send(0, 8'h00, 8'h00);
    end_frame();
    check("read past end oob0", {31'd0, oob0}, 32'd1);
    start_frame(0);
    send(0, 8'hFF, 8'h00);
    send(0, 8'h00, 8'h00);
    end_frame();
    check("oob recleared", {31'd0, oob0}, 32'd0);

    // Abort: cs_n rises together with a byte
    start_frame(0);
    send(0, 8'h80, 8'h00);
    expect_wr(0, 7'd0, 8'hAA); send(0, 8'hAA, 8'h00);
    begin
      tx_exp_t t;
      @(posedge clk); #1;
      t.dut = 0; t.val = 8'hA5;
      tx_q.push_back(t);
      cs0_n = 1'b1; rx_valid = 1'b1; rx_byte = 8'hBB;
      @(posedge clk); #1;
      rx_valid = 1'b0;
    end
    @(negedge clk);
    check("abort reg_out0", reg_out0, 32'h003322AA);
    check("abort tx0", {24'd0, if0.tx_byte}, 32'hA5);

    // Address wrap on the 128-register bridge
    start_frame(1);
    send(1, 8'hFF, 8'h00);
    send(1, 8'h01, 8'h00);
    expect_wr(1, 7'd0, 8'h02); send(1, 8'h02, 8'h00);
    end_frame();
    check("wrap reg0 dut1", {24'd0, reg_out1[7:0]}, 32'h02);
    check("wrap reg127 dut1", {24'd0, reg_out1[1023:1016]}, 32'h00);
    check("wrap oob1", {31'd0, oob1}, 32'd0);
    check("wrap reg_out0 untouched", reg_out0, 32'h003322AA);

    repeat (3) @(negedge clk);
    check("tx_q drained", 32'(tx_q.size()), 32'd0);
    check("wr_q drained", 32'(wr_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
